// File: rtl/mext_acu.sv
// mext_acu -- ALU control unit with multiply/divide sequencing.
//
// Decodes the ALU operation for the execute stage. M-extension ops are
// accepted into a small FSM that drives a multi-cycle multiply/divide unit.
// The FSM stalls fetch/decode until the result is ready.
//
// Ports:
//   MEXT_ACU_CLOCK_50           in   clock, rising edge
//   MEXT_ACU_RESET_InHigh       in   synchronous active-high reset
//   MEXT_ACU_Valid_In           in   instruction in decode is valid
//   MEXT_ACU_AluOP_InBUS[1:0]   in   main-decoder ALU op class
//   MEXT_ACU_Funt3_InBUS[2:0]   in   funct3 field
//   MEXT_ACU_Funt7_b5           in   funct7 bit 5
//   MEXT_ACU_Funt7_b0           in   funct7 bit 0 (M-extension select)
//   MEXT_ACU_Opcode_b5          in   opcode bit 5 (1 = R-type)
//   MEXT_ACU_DivZero_In         in   divisor operand is zero
//   MEXT_ACU_AluControl_OutBUS  out  ALU/MDU operation code
//   MEXT_ACU_Stall_Out          out  hold fetch/decode
//   MEXT_ACU_Start_Out          out  one-cycle load pulse to the MDU
//   MEXT_ACU_Step_Out           out  MDU iterate enable
//   MEXT_ACU_Done_Out           out  one-cycle result-valid pulse
module mext_acu #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_WIDTH   = 6
) (
    input  logic       MEXT_ACU_CLOCK_50,
    input  logic       MEXT_ACU_RESET_InHigh,
    input  logic       MEXT_ACU_Valid_In,
    input  logic [1:0] MEXT_ACU_AluOP_InBUS,
    input  logic [2:0] MEXT_ACU_Funt3_InBUS,
    input  logic       MEXT_ACU_Funt7_b5,
    input  logic       MEXT_ACU_Funt7_b0,
    input  logic       MEXT_ACU_Opcode_b5,
    input  logic       MEXT_ACU_DivZero_In,
    output logic [4:0] MEXT_ACU_AluControl_OutBUS,
    output logic       MEXT_ACU_Stall_Out,
    output logic       MEXT_ACU_Start_Out,
    output logic       MEXT_ACU_Step_Out,
    output logic       MEXT_ACU_Done_Out
);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [4:0]           code_q, code_d;
    logic [4:0]           dec_code;
    logic                 is_mop;

    // M-ext only exists for R-type under AluOP 00; I-type with funct7[0]
    // set is an ordinary immediate op.
    assign is_mop = (MEXT_ACU_AluOP_InBUS == 2'b00) && MEXT_ACU_Opcode_b5
                    && MEXT_ACU_Funt7_b0;

    always_comb begin
        dec_code = 5'd0;
        case (MEXT_ACU_AluOP_InBUS)
            2'b01: dec_code = 5'd0;
            2'b10: dec_code = 5'd11;
            2'b11: dec_code = 5'd10;
            default: begin
                if (is_mop) begin
                    dec_code = {2'b10, MEXT_ACU_Funt3_InBUS};
                end else begin
                    case (MEXT_ACU_Funt3_InBUS)
                        3'b000: dec_code = (MEXT_ACU_Opcode_b5 && MEXT_ACU_Funt7_b5) ? 5'd1 : 5'd0;
                        3'b001: dec_code = 5'd2;
                        3'b010: dec_code = 5'd3;
                        3'b011: dec_code = 5'd4;
                        3'b100: dec_code = 5'd5;
                        3'b101: dec_code = MEXT_ACU_Funt7_b5 ? 5'd7 : 5'd6;
                        3'b110: dec_code = 5'd8;
                        default: dec_code = 5'd9;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        state_d                    = state_q;
        cnt_d                      = cnt_q;
        code_d                     = code_q;
        MEXT_ACU_AluControl_OutBUS = code_q;
        MEXT_ACU_Stall_Out         = 1'b0;
        MEXT_ACU_Start_Out         = 1'b0;
        MEXT_ACU_Step_Out          = 1'b0;
        MEXT_ACU_Done_Out          = 1'b0;
        case (state_q)
            IDLE: begin
                MEXT_ACU_AluControl_OutBUS = dec_code;
                if (MEXT_ACU_Valid_In && is_mop) begin
                    MEXT_ACU_Start_Out = 1'b1;
                    MEXT_ACU_Stall_Out = 1'b1;
                    code_d             = dec_code;
                    if (!MEXT_ACU_Funt3_InBUS[2]) begin
                        state_d = MUL_RUN;
                        cnt_d   = CNT_WIDTH'(MUL_LATENCY - 1);
                    end else if (MEXT_ACU_DivZero_In) begin
                        // Divide-by-zero result is fixed; skip iterating.
                        state_d = DONE;
                    end else begin
                        state_d = DIV_RUN;
                        cnt_d   = CNT_WIDTH'(DIV_LATENCY - 1);
                    end
                end
            end
            MUL_RUN, DIV_RUN: begin
                MEXT_ACU_Step_Out  = 1'b1;
                MEXT_ACU_Stall_Out = 1'b1;
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            default: begin
                MEXT_ACU_Done_Out = 1'b1;
                state_d           = IDLE;
            end
        endcase
        // Outputs are quiet while reset is held, not just after the edge.
        if (MEXT_ACU_RESET_InHigh) begin
            MEXT_ACU_AluControl_OutBUS = 5'd0;
            MEXT_ACU_Stall_Out         = 1'b0;
            MEXT_ACU_Start_Out         = 1'b0;
            MEXT_ACU_Step_Out          = 1'b0;
            MEXT_ACU_Done_Out          = 1'b0;
        end
    end

    always_ff @(posedge MEXT_ACU_CLOCK_50) begin
        if (MEXT_ACU_RESET_InHigh) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

endmodule
